// File: rtl/cnn_pkg.sv
// Shared constants, load FSM state encoding and the image-size clamp used by
// the pooling front end.
package cnn_pkg;

    localparam int DATA_SIZE = 16;
    localparam int N         = 32;
    localparam int IDX_W     = $clog2(N * N);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} load_state_t;

    // Word count for a requested side length: side clamped to N, then squared.
    function automatic logic [DATA_SIZE-1:0] sq_clamp(input logic [DATA_SIZE-1:0] size);
        logic [DATA_SIZE-1:0] s;
        s = (size > DATA_SIZE'(N)) ? DATA_SIZE'(N) : size;
        return DATA_SIZE'(s * s);
    endfunction

endpackage

// File: rtl/img_load_unit_if.sv
// Request/response and RAM read bus of the image loader; master is the loader,
// slave is the requester plus RAM side.
interface img_load_unit_if;
    import cnn_pkg::*;

    logic                 load_en;
    logic [DATA_SIZE-1:0] base_addr;
    logic [DATA_SIZE-1:0] img_size;
    logic                 busy;
    logic                 done;
    logic                 mem_rd_en;
    logic [DATA_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_rdata;

    modport master (
        input  load_en, base_addr, img_size, mem_rdata,
        output busy, done, mem_rd_en, mem_addr
    );

    modport slave (
        output load_en, base_addr, img_size, mem_rdata,
        input  busy, done, mem_rd_en, mem_addr
    );

endinterface

// File: rtl/img_rd_addr_gen.sv
// Issues one RAM read per cycle from base for count words; flags the last read
// and exposes the index of the read currently on the bus.
module img_rd_addr_gen
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [DATA_SIZE-1:0] base_i,
    input  logic [DATA_SIZE-1:0] count_i,
    output logic                 rd_en_o,
    output logic [DATA_SIZE-1:0] addr_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 last_o
);

    logic                 rd_en_q, rd_en_d;
    logic [DATA_SIZE-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0] cnt_q, cnt_d;

    // count_i is latched by the top on the start edge, so it is valid whenever rd_en_q is.
    assign last_o  = rd_en_q && (cnt_q == count_i - DATA_SIZE'(1));
    assign rd_en_o = rd_en_q;
    assign addr_o  = addr_q;
    assign idx_o   = cnt_q[IDX_W-1:0];

    always_comb begin
        rd_en_d = rd_en_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            rd_en_d = 1'b1;
            addr_d  = base_i;
            cnt_d   = '0;
        end else if (rd_en_q) begin
            if (last_o) begin
                rd_en_d = 1'b0;
            end else begin
                addr_d = addr_q + DATA_SIZE'(1);
                cnt_d  = cnt_q + DATA_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/img_load_unit.sv
// Streams an S x S image from RAM into a local N x N buffer and pulses done.
// Optional IMG_LOAD_CLEAR_EN zeroes the whole buffer on each accepted request.
module img_load_unit
    import cnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    img_load_unit_if.master          bus,
    output logic [DATA_SIZE*N*N-1:0] image_o
);

    load_state_t          state_q;
    logic [DATA_SIZE-1:0] t_q;
    logic                 busy_q;
    logic                 done_q;

    logic [N*N-1:0][DATA_SIZE-1:0] image_q;
    logic                          cap_vld_q;
    logic [IDX_W-1:0]              cap_idx_q;

    logic [DATA_SIZE-1:0] t_req;
    logic                 req;
    logic                 rd_en;
    logic                 rd_last;
    logic [IDX_W-1:0]     rd_idx;

    assign t_req = sq_clamp(bus.img_size);
    assign req   = (state_q == IDLE) && bus.load_en;

    img_rd_addr_gen u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .start_i (req && (t_req != '0)),
        .base_i  (bus.base_addr),
        .count_i (t_q),
        .rd_en_o (rd_en),
        .addr_o  (bus.mem_addr),
        .idx_o   (rd_idx),
        .last_o  (rd_last)
    );

    assign bus.mem_rd_en = rd_en;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign image_o       = image_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (req) begin
                        t_q <= t_req;
                        if (t_req == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= READ;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_last) state_q <= DRAIN;
                end
                DRAIN: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data arrives one cycle after the strobe; the pipe carries the word index
    // along, and sequential reads land row-major with stride S.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            image_q   <= '0;
        end else begin
            cap_vld_q <= rd_en;
            cap_idx_q <= rd_idx;
`ifdef IMG_LOAD_CLEAR_EN
            if (req) image_q <= '0;
`endif
            if (cap_vld_q) image_q[cap_idx_q] <= bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_img_load_unit.sv
// Scoreboard bench for img_load_unit: stimulus pushes expected reads/done into
// queues, a negedge monitor pops and compares them against the DUT.
module tb_img_load_unit;
    import cnn_pkg::*;

    typedef struct {
        logic [15:0] addr;
        int          cyc;
    } rd_t;

    logic clk = 1'b0;
    logic reset;
    logic [DATA_SIZE*N*N-1:0] image;

    img_load_unit_if bus();

    img_load_unit dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .image_o (image)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM[a] = a, data valid only in the cycle after the strobe
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= bus.mem_addr;
        else               bus.mem_rdata <= 16'hBAD0;
    end

    int total = 0;
    int bad   = 0;
    rd_t rdq[$];
    int  doneq[$];
    logic [15:0] exp_img [N*N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_img(input string nm);
        int bi;
        bi = -1;
        for (int k = 0; k < N*N; k++) begin
            if (image[k*DATA_SIZE +: DATA_SIZE] !== exp_img[k]) begin
                bi = k;
                break;
            end
        end
        total++;
        if (bi >= 0) begin
            bad++;
            $display("FAIL %s: word %0d got %h want %h", nm, bi,
                     image[bi*DATA_SIZE +: DATA_SIZE], exp_img[bi]);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_rd_en) begin
                if (rdq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexp: got addr %h want no read (cyc %0d)", bus.mem_addr, cyc);
                end else begin
                    rd_t e;
                    e = rdq.pop_front();
                    chk("rd_addr", {16'h0, bus.mem_addr}, {16'h0, e.addr});
                    chk("rd_cyc", cyc, e.cyc);
                end
            end
            if (bus.done) begin
                if (doneq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexp: got done want none (cyc %0d)", cyc);
                end else begin
                    chk("done_cyc", cyc, doneq.pop_front());
                    chk("done_busy", {31'h0, bus.busy}, 32'h0);
                    chk_img("done_image");
                end
            end
        end
    end

    // Push expected reads (first nrd of them) and optionally done; update image model.
    task automatic push_exp(input logic [15:0] base, input logic [15:0] size, input int c0,
                            input int nrd, input bit with_done);
        int t;
        t = int'(sq_clamp(size));
`ifdef IMG_LOAD_CLEAR_EN
        for (int k = 0; k < N*N; k++) exp_img[k] = '0;
`endif
        for (int k = 0; k < t && k < nrd; k++) begin
            rd_t e;
            e.addr = base + 16'(k);
            e.cyc  = c0 + k;
            rdq.push_back(e);
        end
        for (int k = 0; k < t; k++) exp_img[k] = base + 16'(k);
        if (with_done) doneq.push_back((t == 0) ? c0 : c0 + t + 1);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    // Request in the current cycle; returns c0 = cyc value during cycle 1.
    task automatic start_load(input logic [15:0] base, input logic [15:0] size, output int c0);
        tick();
        bus.load_en   = 1'b1;
        bus.base_addr = base;
        bus.img_size  = size;
        c0 = cyc + 1;
        push_exp(base, size, c0, 1 << 30, 1'b1);
        tick();
        bus.load_en = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((rdq.size() != 0 || doneq.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        chk(nm, rdq.size() + doneq.size(), 0);
        repeat (2) tick();
    endtask

    initial begin
        int c0, c1;
        reset         = 1'b1;
        bus.load_en   = 1'b0;
        bus.base_addr = '0;
        bus.img_size  = '0;
        for (int k = 0; k < N*N; k++) exp_img[k] = '0;
        repeat (2) tick();
        chk("rst_rd_en", {31'h0, bus.mem_rd_en}, 32'h0);
        chk("rst_addr", {16'h0, bus.mem_addr}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk_img("rst_image");
        reset = 1'b0;
        repeat (2) tick();

        // base 0x0100, size 4
        chk("t1_busy_c0", {31'h0, bus.busy}, 32'h0);
        start_load(16'h0100, 16'd4, c0);
        chk("t1_busy_c1", {31'h0, bus.busy}, 32'h1);
        wait_cyc(c0 + 16);
        chk("t1_busy_c17", {31'h0, bus.busy}, 32'h1);
        wait_drain("t1_drain");

        // size 0: immediate done, no reads
        start_load(16'h0700, 16'd0, c0);
        wait_drain("t2_drain");

        // address wrap
        start_load(16'hFFFE, 16'd2, c0);
        wait_drain("t3_drain");

        // size 3; ignored pulse in cycle 4; load_en held high from cycle 9 restarts after done
        start_load(16'h0200, 16'd3, c0);
        wait_cyc(c0 + 3);
        bus.load_en = 1'b1; bus.base_addr = 16'h0300; bus.img_size = 16'd2;
        tick();
        bus.load_en = 1'b0;
        wait_cyc(c0 + 8);
        bus.load_en = 1'b1;
        wait_cyc(c0 + 10);
        chk("t4_done_c11", {31'h0, bus.done}, 32'h1);
        c1 = cyc + 2;
        push_exp(16'h0300, 16'd2, c1, 1 << 30, 1'b1);
        wait_cyc(c1);
        bus.load_en = 1'b0;
        wait_drain("t4_drain");

        // size 4 then size 2: words 4..15 kept (or cleared with IMG_LOAD_CLEAR_EN)
        start_load(16'h0100, 16'd4, c0);
        wait_drain("t5a_drain");
        start_load(16'h0500, 16'd2, c0);
        wait_drain("t5b_drain");

        // oversize request clamps to N*N
        start_load(16'h0000, 16'd40, c0);
        wait_drain("t6_drain");
        chk("t6_word1023", {16'h0, image[1023*DATA_SIZE +: DATA_SIZE]}, 32'd1023);

        // reset in cycle 5 of a size-4 load
        tick();
        bus.load_en = 1'b1; bus.base_addr = 16'h0100; bus.img_size = 16'd4;
        c0 = cyc + 1;
        push_exp(16'h0100, 16'd4, c0, 5, 1'b0);
        tick();
        bus.load_en = 1'b0;
        wait_cyc(c0 + 4);
        reset = 1'b1;
        tick();
        for (int k = 0; k < N*N; k++) exp_img[k] = '0;
        chk("t7_rd_en", {31'h0, bus.mem_rd_en}, 32'h0);
        chk("t7_busy", {31'h0, bus.busy}, 32'h0);
        chk("t7_done", {31'h0, bus.done}, 32'h0);
        chk_img("t7_image");
        tick();
        reset = 1'b0;
        repeat (25) tick();
        chk("t7_leftover", rdq.size() + doneq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/img_load_unit.md
Name: img_load_unit

Overview:
- Upstream feeder for the pooling stage.
- On a load request, it streams an imgSize x imgSize image of signed 16-bit words out of the intermediate-layer RAM into a local N x N buffer. It presents the buffer as the flat image bus and pulses a one-cycle done strobe (drives the pool stage's opDone).
- Serves the pool stage's loadImageEnable/loadImgAddrr/RW=read request path.

Parameters:
- DATA_SIZE, 16, word width of addresses, sizes and pixels.
- N, 32, maximum image side; buffer holds N*N words.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- load_en  input  1  level request; sampled only in IDLE
- base_addr  input  DATA_SIZE  RAM address of pixel (0,0)
- img_size  input  DATA_SIZE  image side length
- mem_rd_en  output  1  RAM read strobe
- mem_addr  output  DATA_SIZE  RAM read address
- mem_rdata  input  DATA_SIZE  RAM read data, valid exactly 1 cycle after mem_rd_en
- image  output  DATA_SIZE*N*N  flat buffer; word k at bits [k*DATA_SIZE +: DATA_SIZE]
- busy  output  1  high from accepted request until done
- done  output  1  one-cycle pulse when image is complete

Behaviour:
- Reset values: mem_rd_en=0, mem_addr=0, busy=0, done=0, all image words=0, state=IDLE. Reset wins over every other event, including mid-load. A load in progress is abandoned and no done is produced.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: on a clock edge with load_en=1:
  - latch base_addr and img_size;
  - compute S=min(img_size,N) and T=S*S (DATA_SIZE-bit, at most 1024);
  - set busy=1.
  - If S=0, go to DONE directly; otherwise go to READ.
- READ: one read per cycle.
  - mem_rd_en=1, mem_addr=base+k for k=0..T-1 (addition mod 2^DATA_SIZE; wrap allowed).
  - After issuing k=T-1, go to DRAIN.
- Capture: a delayed valid/index pipe register writes mem_rdata into image word k on the edge ending the cycle after read k. Storage is row-major packed with stride S (word r*S+c), matching the pool stage indexing.
- DRAIN: mem_rd_en=0. Captures the last word, then goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. load_en is ignored during this cycle.
- Latency: request edge E0 → reads in cycles 1..T → done high in cycle T+2. Size 0 gives done in cycle 1.
- load_en while busy is ignored. A new request is not re-sampled until IDLE, so a held-high load_en restarts a load 1 cycle after done.
- img_size>N is clamped to N and loads N*N words.
- Buffer words at index >=T keep their previous contents, unless the optional feature is enabled.
- image is stable between done and the next accepted request.

Optional Feature:
- Macro: IMG_LOAD_CLEAR_EN.
- Defined: the request edge zeroes all N*N buffer words in the same edge, before capture begins, so unused words read 0. Latency is unchanged.
- Undefined: no clear on request; stale words beyond T remain.

Decomposition:
- Shared package cnn_pkg:
  - DATA_SIZE and N constants;
  - state enum load_state_t {IDLE, READ, DRAIN, DONE};
  - function sq_clamp(size) returning T.
- One natural sub-module: img_rd_addr_gen. It holds the issue counter and address adder, and outputs mem_rd_en/mem_addr plus a last flag.
- Capture pipe and buffer stay in the top.

Test Plan:
- Base 0x0100, size 4, RAM[a]=a. Expect:
  - 16 reads at 0x0100..0x010F in cycles 1..16;
  - image words 0..15 = 0x0100..0x010F;
  - done single pulse in cycle 18;
  - busy high in cycles 1..17.
- Size 0. Expect no mem_rd_en, done in cycle 1, image unchanged.
- Size 40, base 0. Expect 1024 reads (clamped), word 1023 = RAM[1023], done in cycle 1026.
- Base 0xFFFE, size 2. Expect addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap); words 0..3 match.
- Size 3 with a second load_en pulse in cycle 4, plus load_en held high. Expect:
  - the cycle-4 pulse is ignored;
  - exactly one done in cycle 11;
  - the next load starts at the edge after done.
- Reset asserted in cycle 5 of a size-4 load. Expect mem_rd_en=0 and busy=0 the next cycle, all image words=0, and no done.
- With IMG_LOAD_CLEAR_EN: load size 4, then size 2. Expect words 4..15 = 0 after the second done; without the macro they retain their first-load values.
